// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, delay-slot aware
// branch redirect, exception flush with cancel of in-flight reads.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000,
    parameter logic [31:0] EXC_PC   = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallD,
    input  logic        branchD,
    input  logic        br_takeD,
    input  logic [31:0] br_targetD,
    input  logic        exc_flush,
    input  logic [31:0] exc_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] instrF,
    output logic [31:0] pcplus4F,
    output logic        adelF,
    output logic        in_delayF,
    output logic [31:0] bad_addrF,
    output logic        validF,
    output logic        stallF
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_CANCEL
    } state_t;

    state_t      r_state, w_state_nx;
    logic [31:0] r_pc, w_pc_nx;
    logic        r_pend_br, w_pend_br_nx;
    logic [31:0] r_pend_tgt, w_pend_tgt_nx;
    logic [31:0] r_instr, w_instr_nx;
    logic        r_adel, w_adel_nx;
    logic        r_in_delay, w_in_delay_nx;
    logic [31:0] r_bad_addr, w_bad_addr_nx;

    logic        w_misal;
    logic        w_br;
    logic [31:0] w_pc_plus4;

    assign w_misal    = (r_pc[1:0] != 2'b00);
    assign w_br       = br_takeD & ~exc_flush;
    assign w_pc_plus4 = r_pc + 32'd4;

    assign inst_req  = (r_state == S_REQ) & ~w_misal;
    assign inst_addr = r_pc;
    assign instrF    = r_instr;
    assign pcplus4F  = w_pc_plus4;
    assign adelF     = r_adel;
    assign in_delayF = r_in_delay;
    assign bad_addrF = r_bad_addr;
    assign validF    = (r_state == S_HOLD);
    assign stallF    = ~validF;

    always_comb begin
        w_state_nx    = r_state;
        w_pc_nx       = r_pc;
        w_pend_br_nx  = r_pend_br;
        w_pend_tgt_nx = r_pend_tgt;
        w_instr_nx    = r_instr;
        w_adel_nx     = r_adel;
        w_in_delay_nx = r_in_delay;
        w_bad_addr_nx = r_bad_addr;

        if (w_br) begin
            w_pend_br_nx  = 1'b1;
            w_pend_tgt_nx = br_targetD;
        end

        unique case (r_state)
            S_REQ: begin
                if (exc_flush) begin
                    // an accepted request still owes us a data beat
                    if (inst_req && inst_addr_ok)
                        w_state_nx = S_CANCEL;
                    else
                        w_state_nx = S_REQ;
                end else if (w_misal) begin
                    w_state_nx    = S_HOLD;
                    w_instr_nx    = 32'd0;
                    w_adel_nx     = 1'b1;
                    w_bad_addr_nx = r_pc;
                    w_in_delay_nx = branchD;
                end else if (inst_addr_ok) begin
                    w_state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (exc_flush) begin
                    w_state_nx = inst_data_ok ? S_REQ : S_CANCEL;
                end else if (inst_data_ok) begin
                    w_state_nx    = S_HOLD;
                    w_instr_nx    = inst_rdata;
                    w_adel_nx     = 1'b0;
                    w_bad_addr_nx = 32'd0;
                    w_in_delay_nx = branchD;
                end
            end
            S_HOLD: begin
                if (exc_flush) begin
                    w_state_nx = S_REQ;
                end else if (!stallD) begin
                    // a branch resolving now targets the slot being handed over
                    w_state_nx   = S_REQ;
                    w_pend_br_nx = 1'b0;
                    if (w_br)
                        w_pc_nx = br_targetD;
                    else if (r_pend_br)
                        w_pc_nx = r_pend_tgt;
                    else
                        w_pc_nx = w_pc_plus4;
                end
            end
            S_CANCEL: begin
                if (inst_data_ok)
                    w_state_nx = S_REQ;
            end
        endcase

        if (exc_flush) begin
            w_pc_nx      = exc_target;
            w_pend_br_nx = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_pend_br  <= 1'b0;
            r_pend_tgt <= 32'd0;
            r_instr    <= 32'd0;
            r_adel     <= 1'b0;
            r_in_delay <= 1'b0;
            r_bad_addr <= 32'd0;
        end else begin
            r_state    <= w_state_nx;
            r_pc       <= w_pc_nx;
            r_pend_br  <= w_pend_br_nx;
            r_pend_tgt <= w_pend_tgt_nx;
            r_instr    <= w_instr_nx;
            r_adel     <= w_adel_nx;
            r_in_delay <= w_in_delay_nx;
            r_bad_addr <= w_bad_addr_nx;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed cycle table plus randomized traffic
// checked against a transaction-level fetch-stream model.
module tb_if_fetch_unit;

    localparam logic [31:0] RPC = 32'hBFC00000;
    localparam logic [31:0] EPC = 32'hBFC00380;
    localparam logic [31:0] Z   = 32'h0;
    localparam logic [31:0] T1  = 32'h80001000;
    localparam logic [31:0] T2  = 32'h80001002;
    localparam logic [31:0] I1  = 32'h24010001;
    localparam logic [31:0] I2  = 32'h10000003;
    localparam logic [31:0] I3  = 32'h24020002;
    localparam logic [31:0] I4  = 32'h10400004;
    localparam logic [31:0] I6  = 32'h11111111;

    logic        clk = 1'b0;
    logic        reset;
    logic        stallD, branchD, br_takeD, exc_flush;
    logic [31:0] br_targetD, exc_target;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic [31:0] instrF, pcplus4F, bad_addrF;
    logic        adelF, in_delayF, validF, stallF;

    int n_tests = 0;
    int n_fail  = 0;

    if_fetch_unit #(.RESET_PC(RPC), .EXC_PC(EPC)) dut (
        .clk(clk), .reset(reset), .stallD(stallD), .branchD(branchD),
        .br_takeD(br_takeD), .br_targetD(br_targetD),
        .exc_flush(exc_flush), .exc_target(exc_target),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata), .instrF(instrF), .pcplus4F(pcplus4F),
        .adelF(adelF), .in_delayF(in_delayF), .bad_addrF(bad_addrF),
        .validF(validF), .stallF(stallF)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int idx,
                         input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d] got=%h exp=%h", nm, idx, got, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5EED_C0DE;
    endfunction

    typedef struct {
        bit          stall, brd, bt;
        logic [31:0] tgt;
        bit          fl;
        logic [31:0] ftgt;
        bit          aok, dok;
        logic [31:0] rdata;
        bit          ereq;
        logic [31:0] eaddr;
        bit          evalid;
        logic [31:0] einstr, epc4;
        bit          eadel;
        logic [31:0] ebad;
        bit          edly;
    } vec_t;

    vec_t tbl[33];

    task automatic idle_inputs();
        stallD = 0; branchD = 0; br_takeD = 0; br_targetD = 0;
        exc_flush = 0; exc_target = 0;
        inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 0;
    endtask

    task automatic check_reset_state(input int tag);
        check("rst_valid", tag, {31'd0, validF}, 0);
        check("rst_stallF", tag, {31'd0, stallF}, 1);
        check("rst_instr", tag, instrF, 0);
        check("rst_pc4", tag, pcplus4F, RPC + 4);
        check("rst_adel", tag, {31'd0, adelF}, 0);
        check("rst_dly", tag, {31'd0, in_delayF}, 0);
        check("rst_bad", tag, bad_addrF, 0);
        check("rst_req", tag, {31'd0, inst_req}, 1);
        check("rst_addr", tag, inst_addr, RPC);
    endtask

    // model of the fetch stream
    logic [31:0] m_pc, m_instr, m_bad, m_tgt, o_addr;
    bit          m_ready, m_adel, m_dly, m_pend;
    bit          outst, o_live;
    int          lat;

    task automatic model_reset();
        m_pc = RPC; m_ready = 0; m_pend = 0; m_tgt = 0;
        m_instr = 0; m_adel = 0; m_bad = 0; m_dly = 0;
        outst = 0; o_live = 0; lat = 0; o_addr = 0;
    endtask

    task automatic rand_cycle(input int c);
        bit exp_req, acc, hand;
        stallD     = ($urandom % 3) == 0;
        branchD    = $urandom % 2;
        br_takeD   = ($urandom % 6) == 0;
        br_targetD = ($urandom & 32'hFFFF_FFFC) | ((($urandom % 8) == 0) ? 32'd2 : 32'd0);
        exc_flush  = ($urandom % 16) == 0;
        exc_target = ($urandom % 2) ? EPC : ($urandom & 32'hFFFF_FFFC);
        inst_addr_ok = inst_req && ($urandom % 2);
        inst_data_ok = outst && (lat == 0);
        inst_rdata   = inst_data_ok ? memf(o_addr) : $urandom;
        #3;
        exp_req = !m_ready && !outst && (m_pc[1:0] == 2'b00);
        check("rnd_req", c, {31'd0, inst_req}, {31'd0, exp_req});
        if (exp_req) check("rnd_addr", c, inst_addr, m_pc);
        check("rnd_valid", c, {31'd0, validF}, {31'd0, m_ready});
        if (m_ready) begin
            check("rnd_instr", c, instrF, m_instr);
            check("rnd_pc4", c, pcplus4F, m_pc + 4);
            check("rnd_adel", c, {31'd0, adelF}, {31'd0, m_adel});
            check("rnd_bad", c, bad_addrF, m_bad);
            check("rnd_dly", c, {31'd0, in_delayF}, {31'd0, m_dly});
        end
        acc  = inst_addr_ok;
        hand = m_ready && !stallD && !exc_flush;
        if (exc_flush) begin
            m_pc = exc_target; m_ready = 0; m_pend = 0; o_live = 0;
        end else if (inst_data_ok && o_live) begin
            m_ready = 1; m_instr = inst_rdata; m_adel = 0; m_bad = 0;
            m_dly = branchD;
        end else if (!m_ready && !outst && m_pc[1:0] != 2'b00) begin
            m_ready = 1; m_instr = 0; m_adel = 1; m_bad = m_pc;
            m_dly = branchD;
        end else if (hand) begin
            m_pc = br_takeD ? br_targetD : (m_pend ? m_tgt : m_pc + 4);
            m_pend = 0; m_ready = 0;
        end
        if (br_takeD && !exc_flush && !hand) begin
            m_pend = 1; m_tgt = br_targetD;
        end
        if (inst_data_ok) outst = 0;
        else if (outst && lat > 0) lat--;
        if (acc) begin
            outst = 1; o_addr = inst_addr; o_live = !exc_flush;
            lat = $urandom % 4;
        end
    endtask

    initial begin
        tbl[0]  = '{0,0,0,Z,0,Z,0,0,Z, 1,RPC,0,Z,Z,0,Z,0};
        tbl[1]  = '{0,0,0,Z,0,Z,1,0,Z, 1,RPC,0,Z,Z,0,Z,0};
        tbl[2]  = '{0,0,0,Z,0,Z,0,0,Z, 0,Z,0,Z,Z,0,Z,0};
        tbl[3]  = '{0,0,0,Z,0,Z,0,1,I1, 0,Z,0,Z,Z,0,Z,0};
        for (int i = 4; i <= 8; i++)
            tbl[i] = '{1,0,0,Z,0,Z,0,0,Z, 0,Z,1,I1,RPC+4,0,Z,0};
        tbl[9]  = '{0,0,0,Z,0,Z,0,0,Z, 0,Z,1,I1,RPC+4,0,Z,0};
        tbl[10] = '{0,0,0,Z,0,Z,1,0,Z, 1,RPC+4,0,Z,Z,0,Z,0};
        tbl[11] = '{0,0,0,Z,0,Z,0,1,I2, 0,Z,0,Z,Z,0,Z,0};
        tbl[12] = '{0,0,0,Z,0,Z,0,0,Z, 0,Z,1,I2,RPC+8,0,Z,0};
        tbl[13] = '{0,0,1,T1,0,Z,1,0,Z, 1,RPC+8,0,Z,Z,0,Z,0};
        tbl[14] = '{0,1,0,Z,0,Z,0,1,I3, 0,Z,0,Z,Z,0,Z,0};
        tbl[15] = '{0,0,0,Z,0,Z,0,0,Z, 0,Z,1,I3,RPC+12,0,Z,1};
        tbl[16] = '{0,0,0,Z,0,Z,1,0,Z, 1,T1,0,Z,Z,0,Z,0};
        tbl[17] = '{0,0,0,Z,1,EPC,0,0,Z, 0,Z,0,Z,Z,0,Z,0};
        tbl[18] = '{0,0,0,Z,0,Z,0,0,Z, 0,Z,0,Z,Z,0,Z,0};
        tbl[19] = '{0,0,0,Z,0,Z,0,1,32'hDEADBEEF, 0,Z,0,Z,Z,0,Z,0};
        tbl[20] = '{0,0,0,Z,0,Z,1,0,Z, 1,EPC,0,Z,Z,0,Z,0};
        tbl[21] = '{0,0,0,Z,0,Z,0,1,I4, 0,Z,0,Z,Z,0,Z,0};
        tbl[22] = '{0,0,0,Z,0,Z,0,0,Z, 0,Z,1,I4,EPC+4,0,Z,0};
        tbl[23] = '{0,0,1,T2,0,Z,1,0,Z, 1,EPC+4,0,Z,Z,0,Z,0};
        tbl[24] = '{0,1,0,Z,0,Z,0,1,Z, 0,Z,0,Z,Z,0,Z,0};
        tbl[25] = '{0,0,0,Z,0,Z,0,0,Z, 0,Z,1,Z,EPC+8,0,Z,1};
        tbl[26] = '{0,0,0,Z,0,Z,0,0,Z, 0,Z,0,Z,Z,0,Z,0};
        tbl[27] = '{1,0,0,Z,0,Z,0,0,Z, 0,Z,1,Z,T2+4,1,T2,0};
        tbl[28] = '{1,0,1,32'h80002000,1,EPC,0,0,Z, 0,Z,1,Z,T2+4,1,T2,0};
        tbl[29] = '{0,0,0,Z,0,Z,1,0,Z, 1,EPC,0,Z,Z,0,Z,0};
        tbl[30] = '{0,0,0,Z,0,Z,0,1,I6, 0,Z,0,Z,Z,0,Z,0};
        tbl[31] = '{0,0,0,Z,0,Z,0,0,Z, 0,Z,1,I6,EPC+4,0,Z,0};
        tbl[32] = '{0,0,0,Z,0,Z,0,0,Z, 1,EPC+4,0,Z,Z,0,Z,0};

        idle_inputs();
        reset = 1;
        @(posedge clk);
        @(posedge clk);
        #4;
        check_reset_state(0);
        @(posedge clk);
        #1;
        reset = 0;

        foreach (tbl[i]) begin
            stallD = tbl[i].stall; branchD = tbl[i].brd;
            br_takeD = tbl[i].bt; br_targetD = tbl[i].tgt;
            exc_flush = tbl[i].fl; exc_target = tbl[i].ftgt;
            inst_addr_ok = tbl[i].aok; inst_data_ok = tbl[i].dok;
            inst_rdata = tbl[i].rdata;
            #3;
            check("tbl_req", i, {31'd0, inst_req}, {31'd0, tbl[i].ereq});
            if (tbl[i].ereq) check("tbl_addr", i, inst_addr, tbl[i].eaddr);
            check("tbl_valid", i, {31'd0, validF}, {31'd0, tbl[i].evalid});
            check("tbl_stallF", i, {31'd0, stallF}, {31'd0, !tbl[i].evalid});
            if (tbl[i].evalid) begin
                check("tbl_instr", i, instrF, tbl[i].einstr);
                check("tbl_pc4", i, pcplus4F, tbl[i].epc4);
                check("tbl_adel", i, {31'd0, adelF}, {31'd0, tbl[i].eadel});
                check("tbl_bad", i, bad_addrF, tbl[i].ebad);
                check("tbl_dly", i, {31'd0, in_delayF}, {31'd0, tbl[i].edly});
            end
            @(posedge clk);
            #1;
        end

        idle_inputs();
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            rand_cycle(c);
            @(posedge clk);
            #1;
        end

        for (int c = 0; c < 50 && !outst; c++) begin
            rand_cycle(3000 + c);
            @(posedge clk);
            #1;
        end
        check("rst_outst_seen", 0, {31'd0, outst}, 1);
        reset = 1;
        exc_flush = 1; exc_target = EPC;
        br_takeD = 1; br_targetD = T1;
        stallD = 0; inst_addr_ok = 1; inst_data_ok = 0;
        @(posedge clk);
        #4;
        check_reset_state(1);
        #1;
        reset = 0;
        idle_inputs();
        model_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameters SHALL be:
  - RESET_PC, 32'hBFC00000, first fetch address after reset.
  - EXC_PC, 32'hBFC00380, exception entry address.
REQ-002 Ports SHALL be:
  - clk  in  1  single clock; all state changes on rising edge.
  - reset  in  1  synchronous, active-high.
  - stallD  in  1  decode stage cannot accept an instruction.
  - branchD  in  1  instruction in D is a branch/jump.
  - br_takeD  in  1  D branch taken; target on br_targetD.
  - br_targetD  in  32  branch/jump target.
  - exc_flush  in  1  exception/eret redirect.
  - exc_target  in  32  redirect address; EXC_PC or EPC, supplied by CP0.
  - inst_req  out  1  instruction memory request.
  - inst_addr  out  32  request address.
  - inst_addr_ok  in  1  request accepted.
  - inst_data_ok  in  1  read data returned.
  - inst_rdata  in  32  read data.
  - instrF  out  32  fetched instruction.
  - pcplus4F  out  32  fetch PC + 4.
  - adelF  out  1  fetch address error.
  - in_delayF  out  1  instrF is a delay-slot instruction.
  - bad_addrF  out  32  faulting fetch address.
  - validF  out  1  F outputs hold a valid instruction.
  - stallF  out  1  fetch busy; equals ~validF.

Function
REQ-003 State SHALL be pc (32b), pend_br (1b), pend_tgt (32b), instr buffer, and FSM {REQ, WAIT, HOLD, CANCEL}.
REQ-004 REQ: inst_req=1 and inst_addr=pc; on inst_addr_ok -> WAIT.
REQ-005 REQ with pc[1:0]!=0: inst_req=0; next cycle -> HOLD with instrF=0, adelF=1, bad_addrF=pc; no memory access.
REQ-006 WAIT: on inst_data_ok, latch inst_rdata into instrF -> HOLD; adelF=0; bad_addrF=0.
REQ-007 HOLD: validF=1; pcplus4F=pc+4 (mod 2^32).
REQ-008 HOLD with stallD=0 is a handover: pc <= pend_br ? pend_tgt : pc+4; pend_br cleared; -> REQ.
REQ-009 HOLD with stallD=1: all F outputs and pc SHALL remain stable.
REQ-010 validF SHALL be 0 in REQ, WAIT and CANCEL.
REQ-011 in_delayF SHALL be registered on entry to HOLD as branchD sampled at that edge, and held until handover.
REQ-012 br_takeD=1 SHALL set pend_br=1 and pend_tgt=br_targetD; the redirect SHALL apply after the delay-slot instruction currently in F is handed over.
REQ-013 exc_flush=1 SHALL, in any state, set pc=exc_target and clear pend_br:
  - from REQ (no addr_ok this cycle) or HOLD -> REQ.
  - from WAIT without inst_data_ok -> CANCEL.
  - from WAIT with inst_data_ok -> REQ, data discarded.
  - from REQ with inst_addr_ok in the same cycle -> CANCEL.
REQ-014 CANCEL: inst_req=0; on inst_data_ok, discard data -> REQ.
REQ-015 Priority SHALL be exc_flush > br_takeD; simultaneous br_takeD is ignored.
REQ-016 At most one memory request SHALL be outstanding.

Reset
REQ-017 reset=1 SHALL set pc=RESET_PC, state=REQ, pend_br=0, pend_tgt=0, instrF=0, adelF=0, in_delayF=0, bad_addrF=0, pcplus4F=RESET_PC+4, validF=0.
REQ-018 reset asserted while a request is outstanding SHALL take priority over all other inputs; the memory side is reset together with this block, so no stale data_ok is expected.

Verification
REQ-019 Reset; addr_ok at cycle 1, data_ok at cycle 3 with 0x24010001 -> validF=1, instrF=0x24010001, pcplus4F=0xBFC00004; next inst_addr=0xBFC00004.
REQ-020 HOLD with stallD=1 for 5 cycles -> outputs stable, inst_req=0; on release -> one handover.
REQ-021 br_takeD=1 with target 0x80001000 while fetching 0xBFC00008 -> delay slot handed over with in_delayF=1, then inst_addr=0x80001000.
REQ-022 exc_flush in WAIT, data_ok 2 cycles later -> data discarded, validF stays 0, next inst_addr=exc_target.
REQ-023 br_targetD=0x80001002 taken -> no inst_req for that PC; adelF=1, bad_addrF=0x80001002, instrF=0.
REQ-024 exc_flush and br_takeD in the same cycle -> fetch resumes at exc_target; pend_br=0.
